// File: rtl/md6_cf_seq_scheduler_if.sv
// rtl/md6_cf_seq_scheduler_if.sv - message stream and N-assembly field bundle for the MD6 sequential scheduler
interface md6_cf_seq_scheduler_if #(
  parameter int W         = 64,
  parameter int BLK_WORDS = 64
);
  logic [W-1:0]           msg_word;
  logic                   msg_valid;
  logic                   msg_last;
  logic                   msg_ready;
  logic                   cf_start;
  logic                   cf_done;
  logic [55:0]            index_out;
  logic [7:0]             level_out;
  logic [3:0]             z_end_out;
  logic [15:0]            padding_zero_M;
  logic [W*BLK_WORDS-1:0] Message;
  logic                   hash_done;
  logic [31:0]            blk_count;

  modport master (
    output msg_word, msg_valid, msg_last, cf_done,
    input  msg_ready, cf_start, index_out, level_out, z_end_out,
           padding_zero_M, Message, hash_done, blk_count
  );

  modport slave (
    input  msg_word, msg_valid, msg_last, cf_done,
    output msg_ready, cf_start, index_out, level_out, z_end_out,
           padding_zero_M, Message, hash_done, blk_count
  );
endinterface

// File: rtl/md6_cf_seq_scheduler.sv
// rtl/md6_cf_seq_scheduler.sv - MD6 sequential-mode block packer/scheduler; MD6_CF_SCHED_PERF_EN builds the blk_count counter
module md6_cf_seq_scheduler #(
  parameter int W         = 64,
  parameter int BLK_WORDS = 64,
  parameter int LEVEL_SEQ = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  md6_cf_seq_scheduler_if.slave    bus
);
  localparam int PW = $clog2(BLK_WORDS + 1);

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DONE} state_t;

  state_t         state;
  logic [PW-1:0]  wr_ptr;
  logic           last_blk;
  logic           accept;
  logic           closing;
  logic [PW-1:0]  words_left;
  logic [15:0]    pad_next;

  always_comb begin
    accept     = 1'b0;
    closing    = 1'b0;
    words_left = '0;
    pad_next   = '0;
    if ((state == IDLE) || (state == FILL)) begin
      accept = bus.msg_valid && bus.msg_ready;
    end
    closing    = accept && (bus.msg_last || (wr_ptr == PW'(BLK_WORDS - 1)));
    // slots left empty once the word now being accepted is stored
    words_left = PW'(BLK_WORDS - 1) - wr_ptr;
    pad_next   = 16'(words_left) * 16'(W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      last_blk           <= 1'b0;
      bus.msg_ready      <= 1'b0;
      bus.cf_start       <= 1'b0;
      bus.index_out      <= '0;
      bus.level_out      <= 8'(LEVEL_SEQ);
      bus.z_end_out      <= '0;
      bus.padding_zero_M <= '0;
      bus.Message        <= '0;
      bus.hash_done      <= 1'b0;
    end else begin
      bus.cf_start  <= 1'b0;
      bus.hash_done <= 1'b0;
      case (state)
        IDLE, FILL: begin
          bus.msg_ready <= 1'b1;
          if (accept) begin
            bus.Message[int'(wr_ptr)*W +: W] <= bus.msg_word;
            wr_ptr <= wr_ptr + 1'b1;
            if (closing) begin
              state              <= ISSUE;
              bus.msg_ready      <= 1'b0;
              last_blk           <= bus.msg_last;
              bus.cf_start       <= 1'b1;
              bus.padding_zero_M <= pad_next;
              bus.z_end_out      <= {3'b000, bus.msg_last};
            end else begin
              state <= FILL;
            end
          end
        end

        // cf_done is deliberately not looked at here
        ISSUE: begin
          state <= WAIT;
        end

        WAIT: begin
          if (bus.cf_done) begin
            if (last_blk) begin
              state         <= DONE;
              bus.hash_done <= 1'b1;
            end else begin
              state              <= FILL;
              bus.index_out      <= bus.index_out + 56'd1;
              bus.Message        <= '0;
              wr_ptr             <= '0;
              bus.z_end_out      <= '0;
              bus.padding_zero_M <= '0;
              bus.msg_ready      <= 1'b1;
            end
          end
        end

        DONE: begin
          state              <= IDLE;
          bus.index_out      <= '0;
          bus.Message        <= '0;
          wr_ptr             <= '0;
          last_blk           <= 1'b0;
          bus.z_end_out      <= '0;
          bus.padding_zero_M <= '0;
          bus.msg_ready      <= 1'b1;
        end

        default: begin
          state         <= IDLE;
          bus.msg_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef MD6_CF_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.blk_count <= '0;
    end else if (bus.cf_start) begin
      bus.blk_count <= bus.blk_count + 32'd1;
    end
  end
`else
  assign bus.blk_count = '0;
`endif

endmodule

// File: tb/tb_md6_cf_seq_scheduler.sv
// tb/tb_md6_cf_seq_scheduler.sv - directed bench for md6_cf_seq_scheduler (blk_count checked per MD6_CF_SCHED_PERF_EN)
module tb_md6_cf_seq_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   exp_blks = 0;

`ifdef MD6_CF_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  md6_cf_seq_scheduler_if bus ();

  md6_cf_seq_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] base;
    int          n;
    logic [15:0] exp_pad;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_msg(input string name, input logic [63:0] base, input int n);
    int bad = -1;
    logic [63:0] a = '0;
    logic [63:0] e = '0;
    logic [63:0] ek;
    for (int k = 0; k < 64; k++) begin
      ek = (k < n) ? base + 64'(k) : 64'd0;
      if (bad < 0 && bus.Message[k*64 +: 64] !== ek) begin
        bad = k;
        a = bus.Message[k*64 +: 64];
        e = ek;
      end
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: Message word %0d got %h expected %h", name, bad, a, e);
    end
  endtask

  task automatic send_word(input logic [63:0] w, input bit last);
    int t = 0;
    bus.msg_word  = w;
    bus.msg_valid = 1'b1;
    bus.msg_last  = last;
    while (bus.msg_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.msg_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got %0b expected 1", bus.msg_ready);
    end
    @(negedge clk);
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
  endtask

  // Sends one block; optional spurious cf_done mid-fill and during the ISSUE cycle.
  task automatic send_block(input string tag, input logic [63:0] base, input int n, input bit last,
                            input logic [55:0] exp_idx, input logic [15:0] exp_pad,
                            input int pause_at, input bit done_in_issue);
    logic [55:0] idx_before;
    for (int k = 0; k < n; k++) begin
      if (k == pause_at) begin
        idx_before = bus.index_out;
        bus.cf_done = 1'b1;
        @(negedge clk);
        bus.cf_done = 1'b0;
        @(negedge clk);
        chk({tag, "_fill_done_ready"}, 64'(bus.msg_ready), 64'd1);
        chk({tag, "_fill_done_start"}, 64'(bus.cf_start), 64'd0);
        chk({tag, "_fill_done_idx"}, 64'(bus.index_out), 64'(idx_before));
      end
      send_word(base + 64'(k), last && (k == n - 1));
    end
    chk({tag, "_cf_start"}, 64'(bus.cf_start), 64'd1);
    chk({tag, "_ready_low"}, 64'(bus.msg_ready), 64'd0);
    chk({tag, "_index"}, 64'(bus.index_out), 64'(exp_idx));
    chk({tag, "_level"}, 64'(bus.level_out), 64'd1);
    chk({tag, "_z_end"}, 64'(bus.z_end_out), 64'(last));
    chk({tag, "_pad"}, 64'(bus.padding_zero_M), 64'(exp_pad));
    chk_msg({tag, "_msg"}, base, n);
    exp_blks++;
    if (done_in_issue) bus.cf_done = 1'b1;
    @(negedge clk);
    bus.cf_done = 1'b0;
    chk({tag, "_start_pulse"}, 64'(bus.cf_start), 64'd0);
    if (done_in_issue) begin
      @(negedge clk);
      chk({tag, "_issue_done_ignored"}, 64'(bus.hash_done), 64'd0);
      chk({tag, "_issue_done_ready"}, 64'(bus.msg_ready), 64'd0);
    end
  endtask

  task automatic next_block(input string tag, input logic [55:0] exp_idx);
    bus.cf_done = 1'b1;
    @(negedge clk);
    bus.cf_done = 1'b0;
    chk({tag, "_ready_back"}, 64'(bus.msg_ready), 64'd1);
    chk({tag, "_next_index"}, 64'(bus.index_out), 64'(exp_idx));
    chk({tag, "_next_pad"}, 64'(bus.padding_zero_M), 64'd0);
    chk({tag, "_next_z"}, 64'(bus.z_end_out), 64'd0);
    chk_msg({tag, "_cleared"}, 64'd0, 0);
  endtask

  task automatic finish_msg(input string tag, input int delay);
    repeat (delay) @(negedge clk);
    bus.cf_done = 1'b1;
    @(negedge clk);
    bus.cf_done = 1'b0;
    chk({tag, "_hash_done"}, 64'(bus.hash_done), 64'd1);
    chk({tag, "_done_ready"}, 64'(bus.msg_ready), 64'd0);
    @(negedge clk);
    chk({tag, "_hash_pulse"}, 64'(bus.hash_done), 64'd0);
    chk({tag, "_idle_ready"}, 64'(bus.msg_ready), 64'd1);
    chk({tag, "_idle_index"}, 64'(bus.index_out), 64'd0);
    chk({tag, "_idle_pad"}, 64'(bus.padding_zero_M), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(bus.msg_ready), 64'd0);
    chk({tag, "_start"}, 64'(bus.cf_start), 64'd0);
    chk({tag, "_index"}, 64'(bus.index_out), 64'd0);
    chk({tag, "_level"}, 64'(bus.level_out), 64'd1);
    chk({tag, "_z"}, 64'(bus.z_end_out), 64'd0);
    chk({tag, "_pad"}, 64'(bus.padding_zero_M), 64'd0);
    chk({tag, "_hash"}, 64'(bus.hash_done), 64'd0);
    chk({tag, "_blk_count"}, 64'(bus.blk_count), 64'd0);
    chk_msg({tag, "_msg"}, 64'd0, 0);
  endtask

  initial begin
    int stall_err;

    vecs[0] = '{64'h0123456789ABCDEF, 1, 16'd4032};
    vecs[1] = '{64'h0, 64, 16'd0};
    vecs[2] = '{64'hA5A5000000000000, 36, 16'd1792};
    vecs[3] = '{64'hFFFFFFFFFFFFFFF0, 2, 16'd3968};
    vecs[4] = '{64'h1000, 63, 16'd64};

    bus.msg_word  = '0;
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
    bus.cf_done   = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 64'(bus.msg_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      send_block($sformatf("vec%0d", i), vecs[i].base, vecs[i].n, 1'b1, 56'd0, vecs[i].exp_pad, -1, 1'b0);
      finish_msg($sformatf("vec%0d", i), 10);
    end
    chk("table_blk_count", 64'(bus.blk_count), PERF ? 64'(exp_blks) : 64'd0);

    // 100-word message with backpressure and spurious cf_done
    send_block("m100_b0", 64'd100, 64, 1'b0, 56'd0, 16'd0, -1, 1'b0);
    bus.msg_word  = 64'hDEADBEEFDEADBEEF;
    bus.msg_valid = 1'b1;
    stall_err = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.msg_ready !== 1'b0 || bus.cf_start !== 1'b0 || bus.hash_done !== 1'b0) stall_err++;
    end
    bus.msg_valid = 1'b0;
    chk("bp_stall_outputs", 64'(stall_err), 64'd0);
    chk("bp_index", 64'(bus.index_out), 64'd0);
    chk("bp_pad", 64'(bus.padding_zero_M), 64'd0);
    chk("bp_z", 64'(bus.z_end_out), 64'd0);
    chk_msg("bp_msg", 64'd100, 64);
    next_block("m100", 56'd1);
    send_block("m100_b1", 64'd164, 36, 1'b1, 56'd1, 16'd1792, 10, 1'b1);
    finish_msg("m100", 3);

    // reset in the middle of the second block
    send_block("rst_b0", 64'd500, 64, 1'b0, 56'd0, 16'd0, -1, 1'b0);
    next_block("rst", 56'd1);
    for (int k = 0; k < 20; k++) send_word(64'd564 + 64'(k), 1'b0);
    chk("rst_pre_index", 64'(bus.index_out), 64'd1);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    exp_blks = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_block("after_rst", 64'h0123456789ABCDEF, 1, 1'b1, 56'd0, 16'd4032, -1, 1'b0);
    finish_msg("after_rst", 2);

    // 130 words -> three compressions
    @(negedge clk);
    rst = 1'b1;
    exp_blks = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_block("m130_b0", 64'h7000, 64, 1'b0, 56'd0, 16'd0, -1, 1'b0);
    next_block("m130_b0", 56'd1);
    send_block("m130_b1", 64'h7040, 64, 1'b0, 56'd1, 16'd0, -1, 1'b0);
    next_block("m130_b1", 56'd2);
    send_block("m130_b2", 64'h7080, 2, 1'b1, 56'd2, 16'd3968, -1, 1'b0);
    finish_msg("m130", 4);
    chk("m130_blk_count", 64'(bus.blk_count), PERF ? 64'd3 : 64'd0);
    chk("m130_exp_blks", 64'(exp_blks), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
